// File: rtl/ghost_dir_sched.sv
// Ghost direction scheduler: shares one random source among the ghost
// movement controllers. Requests are granted round-robin, one at a time.
// A random candidate direction is resolved against the granted ghost's
// legal-move mask, and the result is returned with a one-cycle ack.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an eligible request; picks grant, latches mask
//   SAMPLE  | latches random candidate direction and search step
//   RESOLVE | finds first legal direction, writes dir slot, pulses ack
module ghost_dir_sched #(
    parameter int         NUM_REQ   = 4,
    parameter logic [1:0] DIR_RESET = 2'd0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             rand_in,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   allow,
    output logic [NUM_REQ-1:0]     ack,
    output logic [2*NUM_REQ-1:0]   dir,
    output logic                   stuck,
    output logic                   busy
);

    localparam int            IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0]   NUM_W = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST  = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   gnt;
    logic [3:0]      mask;
    logic [1:0]      cand;
    logic            step;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_vld;
    logic [IW-1:0]      pick;
    logic [IW:0]        slot;
    logic               res_vld;
    logic [1:0]         res_dir;
    logic [1:0]         try_dir;

    // A ghost acked this cycle still has req high; keep it out of the pick.
    assign eligible = req & ~ack;
    assign busy     = (state != IDLE);

    // Round-robin pick: first eligible requester at or above rr, wrapping.
    // The wrap is an explicit compare so non-power-of-2 counts work.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        slot     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = {1'b0, rr} + (IW+1)'(i);
            if (slot >= NUM_W) begin
                slot = slot - NUM_W;
            end
            if (!pick_vld && eligible[slot[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = slot[IW-1:0];
            end
        end
    end

    // Direction search: cand, cand+step, cand+2*step, cand+3*step (mod 4).
    always_comb begin
        res_vld = 1'b0;
        res_dir = cand;
        try_dir = cand;
        for (int k = 0; k < 4; k++) begin
            try_dir = step ? (cand - 2'(k)) : (cand + 2'(k));
            if (!res_vld && mask[try_dir]) begin
                res_vld = 1'b1;
                res_dir = try_dir;
            end
        end
    end

    // Scheduler FSM with registered ack/stuck/dir and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ack   <= '0;
            stuck <= 1'b0;
            dir   <= {NUM_REQ{DIR_RESET}};
            rr    <= '0;
            gnt   <= '0;
            mask  <= '0;
            cand  <= '0;
            step  <= 1'b0;
        end else begin
            ack   <= '0;
            stuck <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt   <= pick;
                        mask  <= allow[{pick, 2'b00} +: 4];
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    cand  <= rand_in[1:0];
                    step  <= rand_in[2];
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    if (res_vld) begin
                        dir[{gnt, 1'b0} +: 2] <= res_dir;
                    end else begin
                        stuck <= 1'b1;
                    end
                    ack[gnt] <= 1'b1;
                    rr       <= (gnt == LAST) ? '0 : (gnt + IW'(1));
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ghost_dir_sched.md
Name: ghost_dir_sched

Overview:
Scheduler sharing the free-running 3-bit random source (16-bit LFSR, one new value per clk) among the ghost movement controllers. Ghosts request a new direction at junctions. The block grants one requester at a time, round-robin. It draws a random candidate direction and resolves it against that ghost's legal-move mask. It then returns the chosen direction with a one-cycle ack. Sits between the random generator and the per-ghost movement FSMs.

Parameters:
NUM_REQ, 4, number of ghost requesters (2..8)
DIR_RESET, 2'd0, direction loaded into every dir slot at reset

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
rand_in  input  3  random value from generator; changes every clk
req  input  NUM_REQ  per-ghost request; held high until matching ack
allow  input  4*NUM_REQ  per-ghost legal-direction mask, bits [4g+3:4g]; bit d=1 means direction d legal
ack  output  NUM_REQ  one-hot, one-cycle pulse: ghost g's new direction valid
dir  output  2*NUM_REQ  registered current direction per ghost, bits [2g+1:2g]
stuck  output  1  one-cycle pulse with ack when granted ghost's mask was 0
busy  output  1  high while state != IDLE

Behaviour:
- Direction encoding: 0=up, 1=right, 2=down, 3=left (clockwise, arithmetic mod 4).
- Reset (async, reset_n=0): state=IDLE, ack=0, stuck=0, busy=0, every dir slot=DIR_RESET, rr pointer=0. Takes effect immediately mid-operation; any in-flight grant is discarded with no ack.
- FSM states: IDLE -> SAMPLE -> RESOLVE -> IDLE.
- IDLE: eligible = req & ~ack (a ghost acked this cycle is masked so it is never re-granted before it drops req). If eligible != 0:
  - select the first set bit searching upward from rr pointer, wrapping at NUM_REQ;
  - latch grant index g and allow[4g+3:4g];
  - go to SAMPLE.
  Otherwise stay in IDLE.
- SAMPLE: latch cand = rand_in[1:0] and step_dir = rand_in[2] (0 = +1 clockwise, 1 = -1 anticlockwise). Go to RESOLVE.
- RESOLVE: search the latched mask for the first legal direction in the order cand, cand+step, cand+2*step, cand+3*step (mod 4).
  - If found: write it to dir slot g.
  - If mask=0: dir slot g is unchanged and stuck is set.
  - Register ack[g]=1, set rr pointer=(g+1) mod NUM_REQ, return to IDLE.
- Timing: req seen in IDLE at cycle T -> ack[g] and updated dir visible in cycle T+3. Back-to-back grants therefore complete every 3 cycles. A new grant can start in the same cycle an ack is high.
- ack and stuck are high for exactly one cycle. dir slots hold between grants.
- req change while a ghost is granted: no effect on the active grant; mask is already latched.
- req[g] dropped before ack: the grant still completes and ack[g] still pulses; the requester ignores it.
- allow changes after the IDLE grant cycle have no effect on that grant.
- NUM_REQ not a power of 2: pointer wrap is explicit compare, not bit truncation.

Test Plan:
- Single request: reset, req=4'b0001, allow[3:0]=4'b1111, force rand_in=3'b010 in the SAMPLE cycle -> ack=4'b0001 at T+3, dir[1:0]=2, stuck=0, other dir slots=DIR_RESET.
- Blocked candidate, clockwise: allow[3:0]=4'b1001, rand_in=3'b001 -> search 1,2,3 -> dir[1:0]=3. Same mask with rand_in=3'b101 -> search 1,0 -> dir[1:0]=0.
- Round-robin fairness: req=4'b1111 held, each ghost drops req the cycle after its ack and reasserts 2 cycles later -> ack order 0,1,2,3,0,...; acks 3 cycles apart; no ghost acked twice in a row.
- Ack masking: ghost 2 holds req one cycle past its ack, no other req -> no second ack[2] from that cycle's IDLE evaluation.
- Stuck: allow[7:4]=4'b0000, req=4'b0010, dir[3:2] previously 1 -> ack=4'b0010 with stuck=1, dir[3:2] stays 1.
- Reset mid-grant: reset_n pulled low in the SAMPLE state -> ack/busy/stuck=0 immediately, all dir=DIR_RESET, no ack after release. A held req is granted afresh starting from ghost 0.
